// File: rtl/key_stream_tx.sv
// rtl/key_stream_tx.sv - serial LSB-first key transmitter for a locked FSM's keyinput pin
// Optional continuous-repeat streaming is enabled by defining KEY_REPEAT_EN.
module key_stream_tx #(
  parameter int KEY_LEN     = 16,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       key_load,
  input  logic [KEY_LEN-1:0]         key_data,
  input  logic                       start,
  input  logic                       abort,
`ifdef KEY_REPEAT_EN
  input  logic                       repeat_mode,
`endif
  output logic                       keyinput,
  output logic                       key_valid,
  output logic                       ready,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(KEY_LEN)-1:0] bit_idx,
  output logic [7:0]                 sent_cnt
);

  localparam int IW = $clog2(KEY_LEN);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IW-1:0] BIT_LAST  = IW'(KEY_LEN - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [KEY_LEN-1:0]   key_reg;
  logic [HW-1:0]        hold_cnt;
  logic                 repeat_on;
  logic                 last_cycle;
  logic                 complete;

`ifdef KEY_REPEAT_EN
  assign repeat_on = repeat_mode;
`else
  assign repeat_on = 1'b0;
`endif

  assign last_cycle = (hold_cnt == HOLD_LAST) && (bit_idx == BIT_LAST);
  // A finished pass counts whether it ends in DONE or wraps; abort always cancels it
  assign complete   = (state == S_SEND) && !abort && last_cycle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_SEND;
      S_SEND: begin
        if (abort)           state_nxt = S_IDLE;
        else if (last_cycle) state_nxt = repeat_on ? S_SEND : S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    key_valid = 1'b0;
    keyinput  = 1'b0;
    case (state)
      S_IDLE: ready = 1'b1;
      S_SEND: begin
        busy      = 1'b1;
        key_valid = 1'b1;
        keyinput  = key_reg[bit_idx];
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // key_reg is only indexed, never shifted, so a retained key can be resent verbatim
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_reg  <= '0;
      bit_idx  <= '0;
      hold_cnt <= '0;
      sent_cnt <= 8'd0;
    end else begin
      if ((state == S_IDLE) && key_load)
        key_reg <= key_data;

      if ((state == S_SEND) && !abort && !last_cycle) begin
        if (hold_cnt == HOLD_LAST) begin
          hold_cnt <= '0;
          bit_idx  <= bit_idx + IW'(1);
        end else begin
          hold_cnt <= hold_cnt + HW'(1);
        end
      end else begin
        hold_cnt <= '0;
        bit_idx  <= '0;
      end

      if (complete && (sent_cnt != 8'hFF))
        sent_cnt <= sent_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_key_stream_tx.sv
// tb/tb_key_stream_tx.sv - directed self-checking bench for key_stream_tx
module tb_key_stream_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_load, a_start, a_abort;
  logic [7:0] a_data;
  logic       a_key, a_valid, a_ready, a_busy, a_done;
  logic [2:0] a_idx;
  logic [7:0] a_cnt;
  logic       b_load, b_start, b_abort;
  logic [7:0] b_data;
  logic       b_key, b_valid, b_ready, b_busy, b_done;
  logic [2:0] b_idx;
  logic [7:0] b_cnt;
`ifdef KEY_REPEAT_EN
  logic       a_rep, b_rep;
`endif

  int checks = 0;
  int errors = 0;

  key_stream_tx #(.KEY_LEN(8), .HOLD_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .key_load(a_load), .key_data(a_data), .start(a_start), .abort(a_abort),
`ifdef KEY_REPEAT_EN
    .repeat_mode(a_rep),
`endif
    .keyinput(a_key), .key_valid(a_valid), .ready(a_ready), .busy(a_busy), .done(a_done),
    .bit_idx(a_idx), .sent_cnt(a_cnt)
  );

  key_stream_tx #(.KEY_LEN(8), .HOLD_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .key_load(b_load), .key_data(b_data), .start(b_start), .abort(b_abort),
`ifdef KEY_REPEAT_EN
    .repeat_mode(b_rep),
`endif
    .keyinput(b_key), .key_valid(b_valid), .ready(b_ready), .busy(b_busy), .done(b_done),
    .bit_idx(b_idx), .sent_cnt(b_cnt)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_load = 0; a_start = 0; a_abort = 0; a_data = 0;
    b_load = 0; b_start = 0; b_abort = 0; b_data = 0;
`ifdef KEY_REPEAT_EN
    a_rep = 0; b_rep = 0;
`endif
    #2;
    checks++;
    if ({a_ready, a_busy, a_done, a_valid, a_key} !== 5'b10000) begin
      errors++; $display("FAIL reset_flags_a: got %b want 10000", {a_ready, a_busy, a_done, a_valid, a_key});
    end
    checks++;
    if (a_idx !== 3'd0 || a_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_counts_a: idx %0d cnt %0d want 0 0", a_idx, a_cnt);
    end
    checks++;
    if ({b_ready, b_busy, b_done, b_valid, b_key} !== 5'b10000) begin
      errors++; $display("FAIL reset_flags_b: got %b want 10000", {b_ready, b_busy, b_done, b_valid, b_key});
    end
    step; step;
    rst = 1'b0;
    step;
  endtask

  task automatic test_basic;
    logic [7:0] k;
    k = 8'hA5;
    a_load = 1; a_data = k;
    step;
    a_load = 0; a_start = 1;
    step;
    a_start = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (a_key !== k[i] || a_valid !== 1'b1 || a_busy !== 1'b1 || a_ready !== 1'b0 || a_idx !== i[2:0]) begin
        errors++; $display("FAIL basic_bit%0d: key %b valid %b busy %b ready %b idx %0d want key %b valid 1 busy 1 ready 0 idx %0d",
                           i, a_key, a_valid, a_busy, a_ready, a_idx, k[i], i);
      end
      step;
    end
    checks++;
    if ({a_done, a_valid, a_key, a_busy, a_ready} !== 5'b10000 || a_idx !== 3'd0) begin
      errors++; $display("FAIL basic_done: done/valid/key/busy/ready %b idx %0d want 10000 idx 0",
                         {a_done, a_valid, a_key, a_busy, a_ready}, a_idx);
    end
    step;
    checks++;
    if (a_ready !== 1'b1 || a_done !== 1'b0 || a_cnt !== 8'd1) begin
      errors++; $display("FAIL basic_after: ready %b done %b cnt %0d want 1 0 1", a_ready, a_done, a_cnt);
    end
  endtask

  task automatic test_hold2;
    logic [7:0] k;
    int j;
    k = 8'h03;
    b_load = 1; b_data = k; b_start = 1;
    step;
    b_load = 0; b_start = 0;
    for (int i = 0; i < 16; i++) begin
      j = i / 2;
      checks++;
      if (b_key !== k[j] || b_valid !== 1'b1 || b_idx !== j[2:0]) begin
        errors++; $display("FAIL hold2_cycle%0d: key %b valid %b idx %0d want key %b valid 1 idx %0d",
                           i, b_key, b_valid, b_idx, k[j], j);
      end
      step;
    end
    checks++;
    if (b_done !== 1'b1 || b_valid !== 1'b0) begin
      errors++; $display("FAIL hold2_done: done %b valid %b want 1 0", b_done, b_valid);
    end
    step;
    checks++;
    if (b_ready !== 1'b1 || b_cnt !== 8'd1) begin
      errors++; $display("FAIL hold2_after: ready %b cnt %0d want 1 1", b_ready, b_cnt);
    end
  endtask

  task automatic test_abort;
    a_load = 1; a_data = 8'hFF;
    step;
    a_load = 0; a_start = 1;
    step;
    a_start = 0;
    step; step; step;
    checks++;
    if (a_key !== 1'b1 || a_valid !== 1'b1 || a_idx !== 3'd3) begin
      errors++; $display("FAIL abort_pre: key %b valid %b idx %0d want 1 1 3", a_key, a_valid, a_idx);
    end
    a_abort = 1;
    step;
    a_abort = 0;
    checks++;
    if ({a_key, a_valid, a_done, a_busy, a_ready} !== 5'b00001 || a_idx !== 3'd0) begin
      errors++; $display("FAIL abort_stop: key/valid/done/busy/ready %b idx %0d want 00001 idx 0",
                         {a_key, a_valid, a_done, a_busy, a_ready}, a_idx);
    end
    step;
    checks++;
    if (a_done !== 1'b0 || a_cnt !== 8'd1) begin
      errors++; $display("FAIL abort_after: done %b cnt %0d want 0 1", a_done, a_cnt);
    end
  endtask

  task automatic test_abort_last;
    a_start = 1;
    step;
    a_start = 0;
    for (int i = 0; i < 7; i++) step;
    checks++;
    if (a_idx !== 3'd7 || a_valid !== 1'b1) begin
      errors++; $display("FAIL abort_last_pre: idx %0d valid %b want 7 1", a_idx, a_valid);
    end
    a_abort = 1;
    step;
    a_abort = 0;
    checks++;
    if (a_done !== 1'b0 || a_valid !== 1'b0 || a_ready !== 1'b1) begin
      errors++; $display("FAIL abort_last_stop: done %b valid %b ready %b want 0 0 1", a_done, a_valid, a_ready);
    end
    a_abort = 1;
    step;
    a_abort = 0;
    checks++;
    if (a_cnt !== 8'd1 || a_ready !== 1'b1 || a_done !== 1'b0) begin
      errors++; $display("FAIL abort_idle: cnt %0d ready %b done %b want 1 1 0", a_cnt, a_ready, a_done);
    end
  endtask

  task automatic test_load_during_send;
    logic [7:0] got;
    a_load = 1; a_data = 8'h0F;
    step;
    a_load = 0; a_start = 1;
    step;
    a_start = 0; a_load = 1; a_data = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      got[i] = a_key;
      step;
    end
    a_load = 0;
    checks++;
    if (got !== 8'h0F || a_done !== 1'b1) begin
      errors++; $display("FAIL load_ignored: stream %h done %b want 0f 1", got, a_done);
    end
    step;
    checks++;
    if (a_cnt !== 8'd2) begin
      errors++; $display("FAIL load_cnt1: cnt %0d want 2", a_cnt);
    end
    a_start = 1;
    step;
    a_start = 0;
    for (int i = 0; i < 8; i++) begin
      got[i] = a_key;
      step;
    end
    step;
    checks++;
    if (got !== 8'h0F || a_cnt !== 8'd3) begin
      errors++; $display("FAIL resend: stream %h cnt %0d want 0f 3", got, a_cnt);
    end
  endtask

  task automatic test_rst_mid;
    logic [7:0] got;
    int nvalid;
    a_load = 1; a_data = 8'hAA;
    step;
    a_load = 0; a_start = 1;
    step;
    a_start = 0;
    for (int i = 0; i < 5; i++) step;
    checks++;
    if (a_idx !== 3'd5 || a_busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre: idx %0d busy %b want 5 1", a_idx, a_busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_ready, a_busy, a_done, a_valid, a_key} !== 5'b10000 || a_idx !== 3'd0 || a_cnt !== 8'd0) begin
      errors++; $display("FAIL rst_async: flags %b idx %0d cnt %0d want 10000 0 0",
                         {a_ready, a_busy, a_done, a_valid, a_key}, a_idx, a_cnt);
    end
    step;
    rst = 1'b0;
    step;
    a_start = 1;
    step;
    a_start = 0;
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      got[i] = a_key;
      if (a_valid === 1'b1) nvalid++;
      step;
    end
    checks++;
    if (got !== 8'h00 || nvalid != 8 || a_done !== 1'b1) begin
      errors++; $display("FAIL rst_zero_key: stream %h valid_cycles %0d done %b want 00 8 1", got, nvalid, a_done);
    end
    step;
    checks++;
    if (a_cnt !== 8'd1) begin
      errors++; $display("FAIL rst_cnt: cnt %0d want 1", a_cnt);
    end
  endtask

`ifdef KEY_REPEAT_EN
  task automatic test_repeat;
    logic [7:0] k;
    int bad;
    k = 8'h5A;
    a_load = 1; a_data = k; a_start = 1; a_rep = 1;
    step;
    a_load = 0; a_start = 0;
    bad = 0;
    for (int i = 0; i < 2400; i++) begin
      if (a_valid !== 1'b1 || a_done !== 1'b0 || a_key !== k[i % 8]) bad++;
      step;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL repeat_stream: bad_cycles %0d want 0", bad);
    end
    checks++;
    if (a_cnt !== 8'd255) begin
      errors++; $display("FAIL repeat_sat: cnt %0d want 255", a_cnt);
    end
    a_abort = 1;
    step;
    a_abort = 0; a_rep = 0;
    checks++;
    if (a_valid !== 1'b0 || a_ready !== 1'b1 || a_done !== 1'b0) begin
      errors++; $display("FAIL repeat_abort: valid %b ready %b done %b want 0 1 0", a_valid, a_ready, a_done);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_hold2;
    test_abort;
    test_abort_last;
    test_load_during_send;
    test_rst_mid;
`ifdef KEY_REPEAT_EN
    test_repeat;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_stream_tx.md
Name: key_stream_tx

Overview:
- Serial key transmitter that drives the single-bit key input of a locked controller FSM.
- Holds a KEY_LEN-bit key loaded in parallel and, on start, shifts it out LSB-first, one bit per HOLD_CYCLES clocks, flagged by key_valid.
- Sits between the key store/test controller and the keyinput0 pin of the obfuscated FSM.
- Counts completed transmissions for trojan-trigger and lockout characterisation.

Parameters:
- KEY_LEN, 16, number of key bits per transmission; must be ≥2.
- HOLD_CYCLES, 1, clock cycles each key bit is held on keyinput; must be ≥1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; asynchronous, active-high.
- key_load  input  1  load key_data into the key register; accepted in IDLE only.
- key_data  input  KEY_LEN  parallel key value.
- start  input  1  begin transmission; accepted in IDLE only.
- abort  input  1  terminate an active transmission.
- keyinput  output  1  serial key bit to the locked FSM.
- key_valid  output  1  keyinput carries a valid key bit.
- ready  output  1  block is in IDLE and will accept start/key_load.
- busy  output  1  transmission in progress.
- done  output  1  one-cycle pulse after a complete transmission.
- bit_idx  output  $clog2(KEY_LEN)  index of the bit currently on keyinput; 0 when idle.
- sent_cnt  output  8  completed transmissions, saturating at 255.

Behaviour:
- Reset (async, any state): state=IDLE, key_reg=0, bit_idx=0, hold_cnt=0, keyinput=0, key_valid=0, busy=0, done=0, ready=1, sent_cnt=0.
- The locked FSM samples on negedge clk. Posedge-registered outputs therefore give a half-cycle setup.
- IDLE:
  - ready=1.
  - key_load=1 at an edge: key_reg←key_data.
  - start=1 at an edge: go to SEND with bit_idx=0, hold_cnt=0.
  - keyinput=key[0] (the new key if key_load was also high) and key_valid=1 from that edge.
  - Simultaneous key_load and start: the load wins, and the newly loaded key is transmitted.
  - abort in IDLE is ignored.
- SEND:
  - busy=1, ready=0, key_valid=1, keyinput=key_reg[bit_idx].
  - hold_cnt increments each cycle. When hold_cnt=HOLD_CYCLES-1 it clears and bit_idx increments.
  - When bit_idx=KEY_LEN-1 and hold_cnt=HOLD_CYCLES-1, go to DONE.
  - key_load and start are ignored while in SEND.
  - key_valid is high for exactly KEY_LEN*HOLD_CYCLES consecutive cycles.
- DONE (one cycle):
  - done=1, keyinput=0, key_valid=0, busy=0, bit_idx=0.
  - sent_cnt increments unless already 255.
  - Next state is IDLE; ready rises the cycle after done.
- abort=1 at an edge in SEND:
  - Next state is IDLE; keyinput=0 and key_valid=0 at that edge.
  - done is not pulsed and sent_cnt is unchanged.
  - abort takes priority over the DONE transition on the last bit.
- key_reg is never shifted. It is retained across transmissions, so a second start resends the same key.
- Latency: start at edge n → first bit visible after edge n; done high in cycle n + KEY_LEN*HOLD_CYCLES.
- sent_cnt is cleared only by rst.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- When defined:
  - Extra input port repeat_mode (1 bit).
  - On the final hold cycle of the last bit with repeat_mode=1, wrap to bit_idx=0 with no gap cycle; key_valid stays high.
  - Each wrap increments sent_cnt (saturating). done is not pulsed on a wrap.
  - repeat_mode=0 at the final cycle → normal DONE. Only abort or rst stops a repeating stream.
- When undefined: the port is absent and every transmission is single-shot.

Test Plan:
- KEY_LEN=8, HOLD=1, load 8'hA5 then start → keyinput 1,0,1,0,0,1,0,1 on cycles 1–8 with key_valid=1; done=1 on cycle 9; sent_cnt=1; ready=1 on cycle 10.
- KEY_LEN=8, HOLD=2, key 8'h03 → keyinput 1,1,1,1,0×12; key_valid for 16 cycles; bit_idx steps every 2 cycles.
- Start key 8'hFF, assert abort on cycle 4 → keyinput=0 and key_valid=0 after that edge; no done; sent_cnt unchanged; ready=1.
- Load 8'h0F, start, then key_load=1 with key_data=8'hF0 during SEND → stream remains 0x0F; a second start sends 0x0F again and sent_cnt=2.
- Assert rst mid-transmission at bit 5 → all outputs at reset values immediately; key_reg=0; a following start without load sends all zeros.
- With KEY_REPEAT_EN, repeat_mode=1, 300 back-to-back wraps → key_valid continuous, no done, sent_cnt saturates at 255; abort stops it on the next edge.
